// File: rtl/mem_access_pkg.sv
// ============================================================================
// mem_access_pkg : shared encodings for the load/store sequencer
// Revision 1.0
// ============================================================================
`default_nettype none

package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam int LANE_W    = 8;
  localparam int NUM_LANES = 4;

  // Byte-enable for an access; half accesses occupy lanes {2*addr[1], 2*addr[1]+1}.
  function automatic logic [NUM_LANES-1:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: return 4'b0001 << lo;
      SZ_HALF: return 4'b0011 << {lo[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lane_align.sv
// ============================================================================
// mem_lane_align : alignment check, load extract/extend and store lane merge
// Revision 1.0
// ============================================================================
`default_nettype none

module mem_lane_align
  import mem_access_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        chk_lo,
  input  logic [1:0]        chk_size,
  output logic              misaligned,
  output logic              size_err,
  input  logic [1:0]        lo,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  input  logic [DATA_W-1:0] rdata,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] merged
);

  logic [DATA_W-1:0]    w_shifted;
  logic [DATA_W-1:0]    w_repl;
  logic [NUM_LANES-1:0] w_be;

  always_comb begin
    misaligned = ((chk_size == SZ_HALF) && chk_lo[0]) ||
                 ((chk_size == SZ_WORD) && (chk_lo != 2'b00));
    size_err   = (chk_size == SZ_ILLEGAL);
  end

  always_comb begin
    w_shifted = rdata >> {lo, 3'b000};
    case (size)
      SZ_BYTE: load_data = {{(DATA_W-8){~is_unsigned & w_shifted[7]}}, w_shifted[7:0]};
      SZ_HALF: load_data = {{(DATA_W-16){~is_unsigned & w_shifted[15]}}, w_shifted[15:0]};
      default: load_data = w_shifted;
    endcase
  end

  // Store data is right-justified, so replicate it across lanes and let the byte-enable pick.
  always_comb begin
    w_be = lane_mask(size, lo);
    case (size)
      SZ_BYTE: w_repl = {NUM_LANES{wdata[7:0]}};
      SZ_HALF: w_repl = {2{wdata[15:0]}};
      default: w_repl = wdata;
    endcase
    merged = rdata;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (w_be[k]) merged[k*LANE_W +: LANE_W] = w_repl[k*LANE_W +: LANE_W];
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
// ============================================================================
// mem_access_ctrl : byte/half/word load-store sequencer in front of a word memory
// Revision 1.0
// ============================================================================
`default_nettype none

module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_WORDS = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              resp_valid_o,
  output logic [DATA_W-1:0] resp_rdata_o,
  output logic              resp_err_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_write_o,
  output logic              mem_read_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  logic [1:0]        r_state;
  logic [1:0]        r_addr_lo;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic              r_write;
  logic [DATA_W-1:0] r_wdata;

  logic              w_misaligned;
  logic              w_size_err;
  logic              w_out_of_range;
  logic              w_req_err;
  logic [DATA_W-1:0] w_load_data;
  logic [DATA_W-1:0] w_merged;

  mem_lane_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .chk_lo      (req_addr_i[1:0]),
    .chk_size    (req_size_i),
    .misaligned  (w_misaligned),
    .size_err    (w_size_err),
    .lo          (r_addr_lo),
    .size        (r_size),
    .is_unsigned (r_unsigned),
    .rdata       (mem_rdata_i),
    .wdata       (r_wdata),
    .load_data   (w_load_data),
    .merged      (w_merged)
  );

  always_comb begin
    w_out_of_range = (req_addr_i >> 2) >= ADDR_W'(MEM_WORDS);
    w_req_err      = w_misaligned | w_size_err | w_out_of_range;
  end

  // Every output is a flop; strobes and responses default low and are set on state entry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_addr_lo    <= 2'b00;
      r_size       <= SZ_BYTE;
      r_unsigned   <= 1'b0;
      r_write      <= 1'b0;
      r_wdata      <= '0;
      req_ready_o  <= 1'b0;
      resp_valid_o <= 1'b0;
      resp_rdata_o <= '0;
      resp_err_o   <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      mem_write_o  <= 1'b0;
      mem_read_o   <= 1'b0;
    end else begin
      req_ready_o  <= 1'b0;
      resp_valid_o <= 1'b0;
      resp_rdata_o <= '0;
      resp_err_o   <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_read_o   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid_i && req_ready_o) begin
            r_addr_lo  <= req_addr_i[1:0];
            r_size     <= req_size_i;
            r_unsigned <= req_unsigned_i;
            r_write    <= req_write_i;
            r_wdata    <= req_wdata_i;
            mem_addr_o <= {req_addr_i[ADDR_W-1:2], 2'b00};
            if (w_req_err) begin
              r_state      <= ST_RESP;
              resp_valid_o <= 1'b1;
              resp_err_o   <= 1'b1;
            end else if (!req_write_i || (req_size_i != SZ_WORD)) begin
              r_state    <= ST_READ;
              mem_read_o <= 1'b1;
            end else begin
              r_state     <= ST_WRITE;
              mem_write_o <= 1'b1;
              mem_wdata_o <= req_wdata_i;
            end
          end else begin
            req_ready_o <= 1'b1;
          end
        end
        ST_READ: begin
          if (r_write) begin
            r_state     <= ST_WRITE;
            mem_write_o <= 1'b1;
            mem_wdata_o <= w_merged;
          end else begin
            r_state      <= ST_RESP;
            resp_valid_o <= 1'b1;
            resp_rdata_o <= w_load_data;
          end
        end
        ST_WRITE: begin
          r_state      <= ST_RESP;
          resp_valid_o <= 1'b1;
        end
        ST_RESP: begin
          r_state     <= ST_IDLE;
          req_ready_o <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
